// File: rtl/inst_fetch_decode.sv
// Fetch/decode stage: fetches 32-bit words into IR, decodes fields, and issues them downstream over valid/ready.
// Latency: start -> imem_req next cycle; imem_valid -> issue_valid next cycle; best case one instruction per 3 cycles.
// Backpressure: issue_valid holds with stable fields until issue_ready; HALT stops everything until reset.
// Optional: define FETCH_TIMEOUT_EN to build the fetch watchdog (TIMEOUT cycles in WAIT without data -> timeout halt).
module inst_fetch_decode #(
  parameter int PC_W    = 16,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_rdata,
  output logic            issue_valid,
  input  logic            issue_ready,
  output logic [4:0]      opcode,
  output logic [4:0]      rdst,
  output logic [4:0]      rsrc1,
  output logic            imm_mode,
  output logic [4:0]      rsrc2,
  output logic [15:0]     isrc,
  output logic            is_logic,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            illegal,
  output logic            timeout
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [4:0] OP_HALT      = 5'b11111;
  localparam logic [4:0] OP_LAST_LEGL = 5'b01100;
  localparam logic [4:0] OP_LOGIC_LO  = 5'b00110;

  state_t          state_q, state_d;
  logic [31:0]     ir_q, ir_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            illegal_q, illegal_d;
  logic [4:0]      rd_op;

  assign rd_op = imem_rdata[31:27];

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`else
  // The watchdog limit has no meaning without the watchdog.
  logic unused_timeout_param;
  assign unused_timeout_param = (TIMEOUT == 0);
`endif

  // Next-state, datapath updates and status decode for the fetch FSM.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    pc_d      = pc_q;
    illegal_d = illegal_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_REQ;
      end
      S_REQ: begin
`ifdef FETCH_TIMEOUT_EN
        cnt_d = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_valid) begin
          // Data arriving on the expiry cycle wins over the watchdog.
          ir_d = imem_rdata;
          if (rd_op == OP_HALT) begin
            state_d = S_HALT;
          end else if (rd_op > OP_LAST_LEGL) begin
            illegal_d = 1'b1;
            state_d   = S_HALT;
          end else begin
            state_d = S_ISSUE;
          end
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_ISSUE: begin
        if (issue_ready) begin
          pc_d    = pc_q + PC_W'(1);
          state_d = S_REQ;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      pc_q      <= '0;
      illegal_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      pc_q      <= pc_d;
      illegal_q <= illegal_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = pc_q;
  assign issue_valid = (state_q == S_ISSUE);
  assign halted      = (state_q == S_HALT);
  assign pc          = pc_q;
  assign illegal     = illegal_q;
`ifdef FETCH_TIMEOUT_EN
  assign timeout     = timeout_q;
`else
  assign timeout     = 1'b0;
`endif

  // Field slices come straight off IR so they are stable while issuing.
  assign opcode   = ir_q[31:27];
  assign rdst     = ir_q[26:22];
  assign rsrc1    = ir_q[21:17];
  assign imm_mode = ir_q[16];
  assign rsrc2    = ir_q[15:11];
  assign isrc     = ir_q[15:0];
  assign is_logic = (ir_q[31:27] >= OP_LOGIC_LO) && (ir_q[31:27] <= OP_LAST_LEGL);

endmodule
